// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token words, alignment FSM states and token lookup.
package tmds_pkg;

   localparam logic [9:0] TokenCtrl0 = 10'b1101010100;
   localparam logic [9:0] TokenCtrl1 = 10'b0010101011;
   localparam logic [9:0] TokenCtrl2 = 10'b0101010100;
   localparam logic [9:0] TokenCtrl3 = 10'b1010101011;

   typedef enum logic [1:0] {
      StSearch,
      StSlip,
      StWait,
      StLocked
   } tmds_state_e;

   typedef struct packed {
      logic       is_token;
      logic [1:0] code;
   } token_info_t;

   function automatic token_info_t token_to_code(input logic [9:0] word);
      token_info_t info;
      info.is_token = 1'b1;
      info.code     = 2'b00;
      case (word)
         TokenCtrl0: info.code = 2'b00;
         TokenCtrl1: info.code = 2'b01;
         TokenCtrl2: info.code = 2'b10;
         TokenCtrl3: info.code = 2'b11;
         default:    info = '0;
      endcase
      return info;
   endfunction

endpackage

// File: rtl/tmds_word_decode.sv
// Combinational TMDS word decode: transition-minimised data recovery plus control-token match.
module tmds_word_decode
   import tmds_pkg::*;
(
   input  logic [9:0] word_i,
   output logic [7:0] data_o,
   output logic       is_token_o,
   output logic [1:0] code_o
);

   logic [7:0]  q;
   token_info_t tok;

   always_comb begin
      q      = word_i[9] ? ~word_i[7:0] : word_i[7:0];
      data_o = '0;
      data_o[0] = q[0];
      // bit 8 selects XOR (1) or XNOR (0) chaining used by the encoder
      for (int i = 1; i < 8; i++) begin
         data_o[i] = word_i[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
      end
   end

   assign tok        = token_to_code(word_i);
   assign is_token_o = tok.is_token;
   assign code_o     = tok.code;

endmodule

// File: rtl/tmds_decoder.sv
// TMDS receive channel: two-stage decode pipeline plus token-rate word alignment FSM
// that requests deserializer bit slips until lock, then watches for lost lock.
module tmds_decoder
   import tmds_pkg::*;
#(
   parameter int unsigned TOKEN_RUN     = 4,
   parameter int unsigned SEARCH_WINDOW = 2048,
   parameter int unsigned SLIP_WAIT     = 16,
   parameter int unsigned MAX_GAP       = 4096
) (
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic [9:0] tmds_in,
   output logic [7:0] data_out,
   output logic [1:0] control_out,
   output logic       ve_out,
   output logic       locked_out,
   output logic       bitslip_out
);

   localparam int unsigned RunW  = $clog2(TOKEN_RUN) + 1;
   localparam int unsigned WinW  = $clog2(SEARCH_WINDOW) + 1;
   localparam int unsigned WaitW = $clog2(SLIP_WAIT) + 1;
   localparam int unsigned GapW  = $clog2(MAX_GAP) + 1;

   localparam logic [RunW-1:0]  RunLimit = RunW'(TOKEN_RUN);
   localparam logic [WinW-1:0]  WinLimit = WinW'(SEARCH_WINDOW);
   localparam logic [WinW-1:0]  WinLast  = WinW'(SEARCH_WINDOW - 1);
   localparam logic [WaitW-1:0] WaitLast = WaitW'(SLIP_WAIT - 1);
   localparam logic [GapW-1:0]  GapLimit = GapW'(MAX_GAP);

   logic [7:0] dec_data;
   logic       dec_tok;
   logic [1:0] dec_code;

   logic [7:0] s1_data_q;
   logic       s1_tok_q;
   logic [1:0] s1_code_q;

   logic [7:0] s2_data_q;
   logic [1:0] s2_ctrl_q;
   logic       s2_ve_q;

   tmds_state_e      state_q, state_d;
   logic [RunW-1:0]  run_q, run_d;
   logic [WinW-1:0]  win_q, win_d;
   logic [WaitW-1:0] wait_q, wait_d;
   logic [GapW-1:0]  gap_q, gap_d;
   logic             locked_q, bitslip_q;

   tmds_word_decode u_word_decode (
      .word_i     (tmds_in),
      .data_o     (dec_data),
      .is_token_o (dec_tok),
      .code_o     (dec_code)
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         s1_data_q <= '0;
         s1_tok_q  <= 1'b0;
         s1_code_q <= '0;
         s2_data_q <= '0;
         s2_ctrl_q <= '0;
         s2_ve_q   <= 1'b0;
      end else begin
         s1_data_q <= dec_data;
         s1_tok_q  <= dec_tok;
         s1_code_q <= dec_code;
         // each output field holds its last value while the other word class is present
         if (s1_tok_q) begin
            s2_ctrl_q <= s1_code_q;
            s2_ve_q   <= 1'b0;
         end else begin
            s2_data_q <= s1_data_q;
            s2_ve_q   <= locked_q;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      win_d   = win_q;
      wait_d  = wait_q;
      gap_d   = gap_q;
      unique case (state_q)
         StSearch: begin
            run_d = s1_tok_q ? ((run_q == RunLimit) ? run_q : run_q + 1'b1) : '0;
            win_d = (win_q == WinLimit) ? win_q : win_q + 1'b1;
            // a completed token run beats an expiring window in the same cycle
            if (run_d == RunLimit) begin
               state_d = StLocked;
               run_d   = '0;
               win_d   = '0;
               gap_d   = '0;
            end else if (win_q == WinLast) begin
               state_d = StSlip;
               run_d   = '0;
               win_d   = '0;
            end
         end
         StSlip: begin
            state_d = StWait;
            wait_d  = '0;
         end
         StWait: begin
            if (wait_q == WaitLast) begin
               state_d = StSearch;
               wait_d  = '0;
               run_d   = '0;
               win_d   = '0;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         StLocked: begin
            gap_d = s1_tok_q ? '0 : ((gap_q == GapLimit) ? gap_q : gap_q + 1'b1);
            if (gap_d == GapLimit) begin
               state_d = StSearch;
               gap_d   = '0;
               run_d   = '0;
               win_d   = '0;
            end
         end
         default: state_d = StSearch;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q   <= StSearch;
         run_q     <= '0;
         win_q     <= '0;
         wait_q    <= '0;
         gap_q     <= '0;
         locked_q  <= 1'b0;
         bitslip_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         run_q     <= run_d;
         win_q     <= win_d;
         wait_q    <= wait_d;
         gap_q     <= gap_d;
         locked_q  <= (state_d == StLocked);
         bitslip_q <= (state_d == StSlip);
      end
   end

   assign data_out    = s2_data_q;
   assign control_out = s2_ctrl_q;
   assign ve_out      = s2_ve_q;
   assign locked_out  = locked_q;
   assign bitslip_out = bitslip_q;

endmodule

// File: doc/tmds_decoder.md
Name: tmds_decoder

Overview:
Receive-side counterpart of the HDMI/DVI TMDS transmit encoder: takes 10-bit parallel TMDS words from one deserialized channel and recovers 8-bit video data, 2-bit control, and the video-enable flag.
It also achieves word alignment by requesting bit slips from the deserializer until control tokens appear at the expected rate, then monitors lock.
One instance per channel (R, G, B); the blue instance's control_out carries {vs,hs}.

Parameters:
TOKEN_RUN, 4, consecutive control tokens required to declare lock (range 2..15).
SEARCH_WINDOW, 2048, cycles without a qualifying token run before issuing a bit slip; must exceed the longest active-video period.
SLIP_WAIT, 16, cycles ignored after a bit slip while the deserializer settles.
MAX_GAP, 4096, cycles allowed between control tokens while locked before dropping lock.

Ports:
clk_in  input  1  pixel clock
rst_n_in  input  1  asynchronous active-low reset
tmds_in  input  10  TMDS word from deserializer, bit 0 first on the wire
data_out  output  8  decoded video data
control_out  output  2  decoded control bits (00,01,10,11)
ve_out  output  1  1 = data_out valid video word, 0 = control period
locked_out  output  1  alignment achieved; outputs trustworthy
bitslip_out  output  1  one-cycle pulse requesting deserializer bit slip

Behaviour:
- Single clock, clk_in. Reset is asynchronous and active-low on rst_n_in: all registers cleared, FSM to SEARCH, all outputs 0.
- Token table: 1101010100->00, 0010101011->01, 0101010100->10, 1010101011->11. Any other word is data.
- Data decode: q[7:0] = tmds[9] ? ~tmds[7:0] : tmds[7:0]; d[0]=q[0]; for i=1..7, d[i] = tmds[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]).
- Pipeline: stage 1 registers tmds_in and token flag/code; stage 2 registers data_out, control_out, ve_out. Word sampled at edge N appears at edge N+2. Latency is fixed at 2 regardless of lock state.
- Control word: ve_out=0, control_out=code, data_out holds its last value.
- Data word: ve_out=1, control_out holds its last value.
- When locked_out=0, ve_out is forced 0 and data_out/control_out still update.
- FSM (evaluated on stage-1 word):
  SEARCH: run counter counts consecutive tokens and clears on any data word. Window counter increments every cycle. Run reaching TOKEN_RUN -> LOCKED. Window reaching SEARCH_WINDOW-1 -> SLIP. If both occur in the same cycle, LOCKED wins.
  SLIP: bitslip_out=1 for exactly one cycle -> WAIT.
  WAIT: counts SLIP_WAIT cycles, ignoring input -> SEARCH, with run and window counters cleared.
  LOCKED: locked_out=1. Gap counter clears on any token and increments otherwise. Gap reaching MAX_GAP -> SEARCH with locked_out deasserted the next cycle and counters cleared. No bit slip is issued directly from LOCKED.
- locked_out and bitslip_out are registered. They are never both 1.
- Counter widths are $clog2 of their limit + 1. Counters saturate and never wrap.

Decomposition:
- Package tmds_pkg: the four control-token constants, the state enum {SEARCH, SLIP, WAIT, LOCKED}, and a token-to-code function. The package is shared with the encoder's control-token case.
- One combinational sub-module, tmds_word_decode (10-bit word in; 8-bit data, is_token, and 2-bit code out), instantiated in stage 1/2.

Test Plan:
- Reset: hold rst_n_in=0 mid-stream, then release -> all outputs 0 immediately (asynchronously); FSM in SEARCH; locked_out=0.
- Lock: drive 4 consecutive 1101010100 words -> locked_out=1 within 2 cycles of the 4th word, no bitslip_out pulse. Then drive 10'b0100000000 -> data_out=8'h00, ve_out=1 two cycles later.
- Decode vectors (locked):
  10'b1000000000 -> 8'hFF
  10'b1111111111 -> 8'h00
  10'b0010101011 -> ve_out=0, control_out=01
  10'b1010101011 -> ve_out=0, control_out=11
- Misalignment: feed the token stream rotated by 3 bits -> bitslip_out pulses once every SEARCH_WINDOW+SLIP_WAIT+1 cycles. The bench model rotates by 1 per slip; lock is reached after exactly 3 slips.
- Lock loss: when locked, send MAX_GAP data words with no tokens -> locked_out falls and ve_out is forced 0. Re-lock follows the token-run rule.
- Boundary: token run completing on the same cycle the window expires -> LOCKED, no bitslip_out. Tokens arriving during WAIT -> ignored, no lock until re-counted in SEARCH.
